// File: rtl/vga_pkg.sv
// Shared VGA timing constants, colours and the cat sprite bitmap, plus the
// per-axis bounce step used by the sprite renderer.
package vga_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_V_ACTIVE = 480;

  localparam int H_FRONT = 16;
  localparam int H_SYNC  = 96;
  localparam int H_BACK  = 48;
  localparam int H_TOTAL = 800;
  localparam int V_FRONT = 10;
  localparam int V_SYNC  = 2;
  localparam int V_BACK  = 33;
  localparam int V_TOTAL = 525;

  // Colours are packed {r[1:0], g[1:0], b[1:0]}.
  localparam logic [5:0] BG_COLOUR = 6'b000001;
  localparam logic [5:0] PALETTE [4] = '{6'b111100, 6'b110011, 6'b001111, 6'b111111};

  // Rows are indexed by v; bit 0 of each row is the leftmost sprite column (u = 0).
  localparam logic [0:15] CAT_BITMAP [16] = '{
    16'b0110000000000110,
    16'b0111000000001110,
    16'b0111100000011110,
    16'b0111111111111110,
    16'b0111111111111110,
    16'b0110011111100110,
    16'b0110011111100110,
    16'b0111111111111110,
    16'b0111110110111110,
    16'b0011111001111100,
    16'b0001111111111000,
    16'b0000111111110000,
    16'b0000011111100000,
    16'b0000111111110000,
    16'b0001111111111000,
    16'b0011111111111100
  };

  typedef enum logic {
    DIR_POS = 1'b0,
    DIR_NEG = 1'b1
  } dir_t;

  typedef struct packed {
    logic [9:0] pos;
    dir_t       dir;
    logic       bounce;
  } axis_t;

  // One frame of motion on one axis; the sprite clamps to the edge and reverses.
  function automatic axis_t step_axis(input logic [9:0] pos, input dir_t dir,
                                      input logic [9:0] pos_max, input logic [3:0] speed);
    axis_t res;
    res.pos    = pos;
    res.dir    = dir;
    res.bounce = 1'b0;
    if (dir == DIR_POS) begin
      if (({1'b0, pos} + {7'd0, speed}) >= {1'b0, pos_max}) begin
        res.pos    = pos_max;
        res.dir    = DIR_NEG;
        res.bounce = 1'b1;
      end else begin
        res.pos = pos + {6'd0, speed};
      end
    end else if (pos <= {6'd0, speed}) begin
      res.pos    = '0;
      res.dir    = DIR_POS;
      res.bounce = 1'b1;
    end else begin
      res.pos = pos - {6'd0, speed};
    end
    return res;
  endfunction

endpackage

// File: rtl/sprite_rom.sv
// Combinational lookup of the 16x16 cat bitmap at local coordinate (u, v).
module sprite_rom
  import vga_pkg::*;
(
  input  logic [3:0] u,
  input  logic [3:0] v,
  output logic       pixel_on
);

  assign pixel_on = CAT_BITMAP[v][u];

endmodule

// File: rtl/sprite_renderer.sv
// Two-stage pixel pipeline drawing a bouncing, scaled cat sprite over a solid
// background, with syncs re-timed to match the colour outputs.
module sprite_renderer
  import vga_pkg::*;
#(
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int SCALE_LOG2 = 2,
  parameter int SPEED      = 2,
  parameter int START_X    = 100,
  parameter int START_Y    = 60
) (
  input  logic       clk_pix,
  input  logic       rst,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       video_active_in,
  input  logic       pause,
  output logic [1:0] r,
  output logic [1:0] g,
  output logic [1:0] b,
  output logic       hsync_out,
  output logic       vsync_out,
  output logic       frame_tick,
  output logic [7:0] bounce_count
);

  localparam int          SPR_W   = 16 << SCALE_LOG2;
  localparam logic [10:0] SPR_W11 = 11'(SPR_W);
  localparam logic [9:0]  X_MAX   = 10'(H_ACTIVE - SPR_W);
  localparam logic [9:0]  Y_MAX   = 10'(V_ACTIVE - SPR_W);
  localparam logic [9:0]  TICK_Y  = 10'(V_ACTIVE);
  localparam logic [3:0]  STEP    = 4'(SPEED);

  logic [9:0]  sx;
  logic [9:0]  sy;
  dir_t        dx;
  dir_t        dy;
  logic [1:0]  pal_idx;
  logic [10:0] off_x;
  logic [10:0] off_y;
  logic        in_box;
  logic [3:0]  u;
  logic [3:0]  v;
  logic        pixel_on;
  axis_t       next_x;
  axis_t       next_y;

  // Left of / above the sprite wraps to a large unsigned offset and falls outside the box.
  assign off_x = {1'b0, pixel_x} - {1'b0, sx};
  assign off_y = {1'b0, pixel_y} - {1'b0, sy};

  always_ff @(posedge clk_pix or posedge rst) begin
    if (rst) begin
      in_box <= 1'b0;
      u      <= '0;
      v      <= '0;
    end else begin
      in_box <= (off_x < SPR_W11) && (off_y < SPR_W11);
      u      <= off_x[SCALE_LOG2 +: 4];
      v      <= off_y[SCALE_LOG2 +: 4];
    end
  end

  sprite_rom u_rom (
    .u        (u),
    .v        (v),
    .pixel_on (pixel_on)
  );

  // The incoming syncs already lag the coordinates by one cycle, so a single
  // register here lines them up with the colour stage.
  always_ff @(posedge clk_pix or posedge rst) begin
    if (rst) begin
      {r, g, b} <= '0;
      hsync_out <= 1'b1;
      vsync_out <= 1'b1;
    end else begin
      hsync_out <= hsync_in;
      vsync_out <= vsync_in;
      if (!video_active_in) begin
        {r, g, b} <= '0;
      end else if (in_box && pixel_on) begin
        {r, g, b} <= PALETTE[pal_idx];
      end else begin
        {r, g, b} <= BG_COLOUR;
      end
    end
  end

  always_comb begin
    next_x = step_axis(sx, dx, X_MAX, STEP);
    next_y = step_axis(sy, dy, Y_MAX, STEP);
  end

  // The tick fires at the start of vertical blanking, so the position never
  // changes while visible lines are being drawn.
  always_ff @(posedge clk_pix or posedge rst) begin
    if (rst) begin
      frame_tick   <= 1'b0;
      sx           <= 10'(START_X);
      sy           <= 10'(START_Y);
      dx           <= DIR_POS;
      dy           <= DIR_POS;
      pal_idx      <= '0;
      bounce_count <= '0;
    end else begin
      frame_tick <= (pixel_x == '0) && (pixel_y == TICK_Y);
      if (frame_tick && !pause) begin
        sx <= next_x.pos;
        dx <= next_x.dir;
        sy <= next_y.pos;
        dy <= next_y.dir;
        if (next_x.bounce || next_y.bounce) begin
          bounce_count <= bounce_count + 8'd1;
          pal_idx      <= pal_idx + 2'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sprite_renderer.sv
// Bench for sprite_renderer: a default-placed instance and one started next to
// the bottom-right corner, both checked against a frame-level reference model.
module tb_sprite_renderer;
  import vga_pkg::*;

  localparam int SPEED = 2;
  localparam int SPR   = 64;
  localparam int CELL  = SPR / 16;
  localparam int XMAX  = DEF_H_ACTIVE - SPR;
  localparam int YMAX  = DEF_V_ACTIVE - SPR;

  typedef struct packed {
    int sx;
    int sy;
    int dx;
    int dy;
    int pal;
    int cnt;
  } model_t;

  typedef struct {
    bit         valid;
    int         x;
    int         y;
    bit         tick;
    logic [5:0] rgb_a;
    logic [5:0] rgb_c;
    logic       hs;
    logic       vs;
    logic [7:0] cnt_a;
    logic [7:0] cnt_c;
  } hist_t;

  typedef struct {
    int         x;
    int         y;
    logic [5:0] rgb;
  } vec_t;

  logic       clk_pix = 1'b0;
  logic       rst;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic       hsync_in;
  logic       vsync_in;
  logic       video_active_in;
  logic       pause;
  logic [1:0] r_a, g_a, b_a, r_c, g_c, b_c;
  logic       hs_a, vs_a, tick_a, hs_c, vs_c, tick_c;
  logic [7:0] cnt_a, cnt_c;

  int     vectors = 0;
  int     miscompares = 0;
  int     ticks_seen = 0;
  int     hs_low = 0;
  int     prev_x = 5;
  int     prev_y = 5;
  model_t ma, mc;
  hist_t  h1, h2;
  vec_t   tab [12];

  always #20 clk_pix = ~clk_pix;

  sprite_renderer dut (
    .clk_pix(clk_pix), .rst(rst), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .video_active_in(video_active_in),
    .pause(pause), .r(r_a), .g(g_a), .b(b_a), .hsync_out(hs_a), .vsync_out(vs_a),
    .frame_tick(tick_a), .bounce_count(cnt_a)
  );

  sprite_renderer #(.START_X(574), .START_Y(414)) dut_c (
    .clk_pix(clk_pix), .rst(rst), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .video_active_in(video_active_in),
    .pause(pause), .r(r_c), .g(g_c), .b(b_c), .hsync_out(hs_c), .vsync_out(vs_c),
    .frame_tick(tick_c), .bounce_count(cnt_c)
  );

  function automatic logic hsOf(input int x);
    return !((x >= DEF_H_ACTIVE + H_FRONT) && (x < DEF_H_ACTIVE + H_FRONT + H_SYNC));
  endfunction

  function automatic logic vsOf(input int y);
    return !((y >= DEF_V_ACTIVE + V_FRONT) && (y < DEF_V_ACTIVE + V_FRONT + V_SYNC));
  endfunction

  function automatic model_t stepModel(input model_t s);
    bit hit = 0;
    if (s.dx > 0) begin
      if (s.sx + SPEED >= XMAX) begin s.sx = XMAX; s.dx = -1; hit = 1; end
      else s.sx = s.sx + SPEED;
    end else if (s.sx <= SPEED) begin s.sx = 0; s.dx = 1; hit = 1; end
    else s.sx = s.sx - SPEED;
    if (s.dy > 0) begin
      if (s.sy + SPEED >= YMAX) begin s.sy = YMAX; s.dy = -1; hit = 1; end
      else s.sy = s.sy + SPEED;
    end else if (s.sy <= SPEED) begin s.sy = 0; s.dy = 1; hit = 1; end
    else s.sy = s.sy - SPEED;
    if (hit) begin
      s.cnt = (s.cnt + 1) % 256;
      s.pal = (s.pal + 1) % 4;
    end
    return s;
  endfunction

  function automatic logic [5:0] renderModel(input model_t s, input int x, input int y);
    int lx, ly;
    if (x >= DEF_H_ACTIVE || y >= DEF_V_ACTIVE) return 6'b0;
    lx = x - s.sx;
    ly = y - s.sy;
    if (lx >= 0 && lx < SPR && ly >= 0 && ly < SPR && CAT_BITMAP[ly / CELL][lx / CELL])
      return PALETTE[s.pal];
    return BG_COLOUR;
  endfunction

  task automatic resetModels();
    ma.sx = 100; ma.sy = 60;  ma.dx = 1; ma.dy = 1; ma.pal = 0; ma.cnt = 0;
    mc.sx = 574; mc.sy = 414; mc.dx = 1; mc.dy = 1; mc.pal = 0; mc.cnt = 0;
    h1.valid = 0;
    h2.valid = 0;
  endtask

  // Outputs now belong to the pixel presented two drives ago; frame_tick to the last one.
  task automatic checkOutput();
    bit bad;
    if (h2.valid) begin
      bad = 0;
      vectors++;
      if ({r_a, g_a, b_a} !== h2.rgb_a) begin
        $display("[TB] FAIL rgb_default (%0d,%0d): got %b expected %b", h2.x, h2.y, {r_a, g_a, b_a}, h2.rgb_a);
        bad = 1;
      end
      if ({r_c, g_c, b_c} !== h2.rgb_c) begin
        $display("[TB] FAIL rgb_corner (%0d,%0d): got %b expected %b", h2.x, h2.y, {r_c, g_c, b_c}, h2.rgb_c);
        bad = 1;
      end
      if (hs_a !== h2.hs || hs_c !== h2.hs || vs_a !== h2.vs || vs_c !== h2.vs) begin
        $display("[TB] FAIL syncs (%0d,%0d): got hs %b/%b vs %b/%b expected hs %b vs %b",
                 h2.x, h2.y, hs_a, hs_c, vs_a, vs_c, h2.hs, h2.vs);
        bad = 1;
      end
      if (cnt_a !== h2.cnt_a || cnt_c !== h2.cnt_c) begin
        $display("[TB] FAIL bounce_count (%0d,%0d): got %0d/%0d expected %0d/%0d",
                 h2.x, h2.y, cnt_a, cnt_c, h2.cnt_a, h2.cnt_c);
        bad = 1;
      end
      if (bad) miscompares++;
      if (hs_a === 1'b0) hs_low++;
    end
    if (h1.valid) begin
      vectors++;
      if (tick_a !== h1.tick || tick_c !== h1.tick) begin
        $display("[TB] FAIL frame_tick (%0d,%0d): got %b/%b expected %b", h1.x, h1.y, tick_a, tick_c, h1.tick);
        miscompares++;
      end
      if (tick_a === 1'b1) ticks_seen++;
    end
  endtask

  task automatic applyStimulus(input int x, input int y, input bit use_tab, input logic [5:0] tab_rgb);
    hist_t rec;
    @(negedge clk_pix);
    checkOutput();
    hsync_in        = hsOf(prev_x);
    vsync_in        = vsOf(prev_y);
    video_active_in = (prev_x < DEF_H_ACTIVE) && (prev_y < DEF_V_ACTIVE);
    pixel_x         = 10'(x);
    pixel_y         = 10'(y);
    rec.tick = (x == 0) && (y == DEF_V_ACTIVE);
    if (rec.tick && !pause) begin
      ma = stepModel(ma);
      mc = stepModel(mc);
    end
    rec.valid = 1;
    rec.x     = x;
    rec.y     = y;
    rec.rgb_a = use_tab ? tab_rgb : renderModel(ma, x, y);
    rec.rgb_c = renderModel(mc, x, y);
    rec.hs    = hsOf(x);
    rec.vs    = vsOf(y);
    rec.cnt_a = 8'(ma.cnt);
    rec.cnt_c = 8'(mc.cnt);
    h2 = h1;
    h1 = rec;
    prev_x = x;
    prev_y = y;
  endtask

  // Trailing blanking pixels let the position update land before anything visible.
  task automatic frameTick();
    applyStimulus(0, DEF_V_ACTIVE, 0, '0);
    applyStimulus(1, DEF_V_ACTIVE, 0, '0);
    applyStimulus(2, DEF_V_ACTIVE, 0, '0);
  endtask

  task automatic checkValue(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
      miscompares++;
    end
  endtask

  task automatic checkReset(input string name);
    vectors++;
    if ({r_a, g_a, b_a, r_c, g_c, b_c} !== 12'd0 || {hs_a, vs_a, hs_c, vs_c} !== 4'b1111 ||
        {tick_a, tick_c} !== 2'b00 || cnt_a !== 8'd0 || cnt_c !== 8'd0) begin
      $display("[TB] FAIL %s: got rgb %b/%b hs %b/%b vs %b/%b tick %b/%b cnt %0d/%0d expected all zero, syncs 1",
               name, {r_a, g_a, b_a}, {r_c, g_c, b_c}, hs_a, hs_c, vs_a, vs_c, tick_a, tick_c, cnt_a, cnt_c);
      miscompares++;
    end
  endtask

  task automatic randomPixel(output int x, output int y);
    int sel = int'($urandom_range(0, 2));
    if (sel == 0) begin
      x = int'($urandom_range(0, 799));
      y = int'($urandom_range(0, 524));
    end else if (sel == 1) begin
      x = ma.sx - 2 + int'($urandom_range(0, SPR + 3));
      y = ma.sy - 2 + int'($urandom_range(0, SPR + 3));
    end else begin
      x = mc.sx - 2 + int'($urandom_range(0, SPR + 3));
      y = mc.sy - 2 + int'($urandom_range(0, SPR + 3));
    end
    if (x < 0) x = 0;
    if (y < 0) y = 0;
    if (x == 0 && y == DEF_V_ACTIVE) x = 1;
  endtask

  initial begin
    #10ms;
    $display("[TB] FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t0, x, y;
    tab[0]  = '{100, 60,  BG_COLOUR};
    tab[1]  = '{99,  60,  BG_COLOUR};
    tab[2]  = '{700, 60,  6'b000000};
    tab[3]  = '{104, 60,  6'b111100};
    tab[4]  = '{163, 123, BG_COLOUR};
    tab[5]  = '{108, 76,  6'b111100};
    tab[6]  = '{112, 80,  BG_COLOUR};
    tab[7]  = '{164, 60,  BG_COLOUR};
    tab[8]  = '{100, 124, BG_COLOUR};
    tab[9]  = '{130, 100, 6'b111100};
    tab[10] = '{100, 480, 6'b000000};
    tab[11] = '{639, 479, BG_COLOUR};

    rst = 1'b1;
    pause = 1'b0;
    pixel_x = 10'd5;
    pixel_y = 10'd5;
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    video_active_in = 1'b1;
    resetModels();
    repeat (3) @(negedge clk_pix);
    checkReset("reset_state");
    rst = 1'b0;

    for (int i = 0; i < 12; i++) applyStimulus(tab[i].x, tab[i].y, 1, tab[i].rgb);

    hs_low = 0;
    for (int i = 600; i < 800; i++) applyStimulus(i, 100, 0, '0);
    applyStimulus(0, 101, 0, '0);
    applyStimulus(1, 101, 0, '0);
    checkValue("hsync_pulse_width", hs_low, H_SYNC);

    pause = 1'b1;
    t0 = ticks_seen;
    repeat (3) begin
      frameTick();
      applyStimulus(578, 414, 0, '0);
      applyStimulus(574, 414, 0, '0);
      applyStimulus(104, 60, 0, '0);
    end
    applyStimulus(3, 481, 0, '0);
    applyStimulus(4, 481, 0, '0);
    checkValue("paused_tick_pulses", ticks_seen - t0, 3);
    checkValue("paused_bounce_count", int'(cnt_c), 0);
    pause = 1'b0;

    frameTick();
    checkValue("corner_bounce_count", int'(cnt_c), 1);
    checkValue("default_bounce_count", int'(cnt_a), 0);
    foreach (tab[i]) begin end
    applyStimulus(576, 416, 0, '0);
    applyStimulus(580, 416, 0, '0);
    applyStimulus(575, 416, 0, '0);
    applyStimulus(576, 415, 0, '0);
    applyStimulus(639, 479, 0, '0);
    frameTick();
    checkValue("corner_count_after_return", int'(cnt_c), 1);
    applyStimulus(574, 414, 0, '0);
    applyStimulus(578, 414, 0, '0);
    applyStimulus(573, 414, 0, '0);
    applyStimulus(637, 477, 0, '0);

    for (int f = 0; f < 320; f++) begin
      pause = ($urandom_range(0, 7) == 0);
      for (int k = 0; k < 12; k++) begin
        randomPixel(x, y);
        applyStimulus(x, y, 0, '0);
      end
      frameTick();
    end
    pause = 1'b0;
    applyStimulus(5, 5, 0, '0);
    applyStimulus(6, 5, 0, '0);
    applyStimulus(7, 5, 0, '0);

    @(negedge clk_pix);
    #5;
    rst = 1'b1;
    #1;
    checkReset("async_reset_midframe");
    repeat (3) @(negedge clk_pix);
    checkReset("reset_held");
    rst = 1'b0;
    resetModels();
    applyStimulus(104, 60, 0, '0);
    applyStimulus(100, 60, 0, '0);
    applyStimulus(130, 100, 0, '0);
    applyStimulus(578, 414, 0, '0);
    frameTick();
    applyStimulus(106, 62, 0, '0);
    applyStimulus(104, 62, 0, '0);
    applyStimulus(576, 416, 0, '0);
    applyStimulus(580, 416, 0, '0);
    applyStimulus(2, 481, 0, '0);
    applyStimulus(3, 481, 0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
